// File: rtl/mmu_xbar_pkg.sv
// Shared definitions for the mmu_xbar crossbar: permission bit positions,
// requester FSM states and a constant-width helper.
package mmu_xbar_pkg;

  localparam int unsigned PERM_R = 0;
  localparam int unsigned PERM_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_DATA = 2'd2,
    ST_FLT  = 2'd3
  } req_st_t;

  // Minimum of 1 so single-entry vectors still get a legal index width
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mmu_xbar_rr_arbiter.sv
// Round-robin arbiter for one mmu_xbar bank: N-wide request to one-hot grant.
// The pointer moves past the winner only when something is granted.
module rr_arbiter
  import mmu_xbar_pkg::*;
#(
  parameter int unsigned N = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int unsigned PW = clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic          w_any;

  always_comb begin
    int unsigned s;
    logic [PW-1:0] idx;
    o_gnt  = '0;
    w_any  = 1'b0;
    w_next = r_ptr;
    s      = 0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      s = 32'(r_ptr) + k;
      if (s >= N) s = s - N;
      idx = PW'(s);
      if (!w_any && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        w_any      = 1'b1;
        w_next     = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (w_any) r_ptr <= w_next;
  end

endmodule

// File: rtl/mmu_xbar.sv
// NREQ requesters sharing NBANK single-port RAM banks with per-bank round-robin,
// permission checks and fault replies. Optional fault capture: MMU_XBAR_FAULT_LOG_EN.
module mmu_xbar
  import mmu_xbar_pkg::*;
#(
  parameter int unsigned             WORDSIZE   = 16,
  parameter int unsigned             AW         = 16,
  parameter int unsigned             NREQ       = 4,
  parameter int unsigned             NBANK      = 4,
  parameter logic [NBANK*AW-1:0]     BANK_BASE  = {16'd7168, 16'd6144, 16'd3072, 16'd0},
  parameter logic [NBANK*AW-1:0]     BANK_DEPTH = {16'd3072, 16'd1024, 16'd3072, 16'd3072},
  parameter logic [NREQ*NBANK*2-1:0] PERM       = '1
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*WORDSIZE-1:0] req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          fault,
  output logic [NREQ*WORDSIZE-1:0] rdata
`ifdef MMU_XBAR_FAULT_LOG_EN
  ,
  output logic                     flt_valid,
  output logic [2:0]               flt_req,
  output logic [AW-1:0]            flt_addr,
  input  logic                     flt_clr
`endif
);

  localparam int unsigned BW = clog2(NBANK);

  req_st_t                   r_st    [NREQ];
  logic [NREQ-1:0]           w_ok;
  logic [BW-1:0]             w_bank  [NREQ];
  logic [AW-1:0]             w_off   [NREQ];
  logic [WORDSIZE-1:0]       w_rsel  [NREQ];
  logic [NREQ-1:0]           w_breq  [NBANK];
  logic [NREQ-1:0]           w_gnt   [NBANK];
  logic [NREQ-1:0]           w_granted;
  logic [NBANK*WORDSIZE-1:0] w_brd;

  // Inputs are held until ack, so decode stays valid through ARB and DATA
  always_comb begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      w_ok[r]   = 1'b0;
      w_bank[r] = '0;
      w_off[r]  = '0;
      w_rsel[r] = '0;
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (req_addr[r*AW +: AW] >= BANK_BASE[b*AW +: AW] &&
            (req_addr[r*AW +: AW] - BANK_BASE[b*AW +: AW]) < BANK_DEPTH[b*AW +: AW]) begin
          w_ok[r]   = req_we[r] ? PERM[r*NBANK*2 + b*2 + PERM_W]
                                : PERM[r*NBANK*2 + b*2 + PERM_R];
          w_bank[r] = BW'(b);
          w_off[r]  = req_addr[r*AW +: AW] - BANK_BASE[b*AW +: AW];
        end
        if (w_bank[r] == BW'(b)) w_rsel[r] = w_brd[b*WORDSIZE +: WORDSIZE];
      end
    end
    for (int unsigned b = 0; b < NBANK; b++) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        w_breq[b][r] = (r_st[r] == ST_ARB) && (w_bank[r] == BW'(b));
      end
    end
  end

  always_comb begin
    w_granted = '0;
    for (int unsigned b = 0; b < NBANK; b++) w_granted = w_granted | w_gnt[b];
  end

  for (genvar gb = 0; gb < NBANK; gb++) begin : g_bank
    localparam int unsigned DEPTH = 32'(BANK_DEPTH[gb*AW +: AW]);
    localparam int unsigned IW    = clog2(DEPTH);

    logic [WORDSIZE-1:0] r_mem [DEPTH];
    logic [WORDSIZE-1:0] r_rd;
    logic                w_en;
    logic                w_we;
    logic [IW-1:0]       w_a;
    logic [WORDSIZE-1:0] w_wd;

    rr_arbiter #(.N(NREQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_breq[gb]),
      .o_gnt (w_gnt[gb])
    );

    always_comb begin
      w_en = |w_gnt[gb];
      w_we = 1'b0;
      w_a  = '0;
      w_wd = '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
        if (w_gnt[gb][r]) begin
          w_we = req_we[r];
          w_a  = IW'(w_off[r]);
          w_wd = req_wdata[r*WORDSIZE +: WORDSIZE];
        end
      end
    end

    // Read-first: the read port sees the word as it was before this edge's write
    always_ff @(posedge clk) begin
      if (w_en) begin
        if (w_we) r_mem[w_a] <= w_wd;
        r_rd <= r_mem[w_a];
      end
    end

    assign w_brd[gb*WORDSIZE +: WORDSIZE] = r_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREQ; r++) r_st[r] <= ST_IDLE;
      ack   <= '0;
      fault <= '0;
      rdata <= '0;
    end else begin
      ack <= '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
        case (r_st[r])
          ST_IDLE: if (req[r]) r_st[r] <= w_ok[r] ? ST_ARB : ST_FLT;
          ST_ARB:  if (w_granted[r]) r_st[r] <= ST_DATA;
          ST_DATA: begin
            ack[r]   <= 1'b1;
            fault[r] <= 1'b0;
            rdata[r*WORDSIZE +: WORDSIZE] <= req_we[r] ? '0 : w_rsel[r];
            r_st[r]  <= ST_IDLE;
          end
          ST_FLT: begin
            ack[r]   <= 1'b1;
            fault[r] <= 1'b1;
            rdata[r*WORDSIZE +: WORDSIZE] <= '0;
            r_st[r]  <= ST_IDLE;
          end
          default: r_st[r] <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MMU_XBAR_FAULT_LOG_EN
  logic          w_nf;
  logic [2:0]    w_nf_req;
  logic [AW-1:0] w_nf_addr;

  // Lowest-numbered requester wins when several fault in the same cycle
  always_comb begin
    w_nf      = 1'b0;
    w_nf_req  = '0;
    w_nf_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_st[NREQ-1-i] == ST_IDLE && req[NREQ-1-i] && !w_ok[NREQ-1-i]) begin
        w_nf      = 1'b1;
        w_nf_req  = 3'(NREQ - 1 - i);
        w_nf_addr = req_addr[(NREQ-1-i)*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_valid <= 1'b0;
      flt_req   <= '0;
      flt_addr  <= '0;
    end else if (w_nf && (!flt_valid || flt_clr)) begin
      flt_valid <= 1'b1;
      flt_req   <= w_nf_req;
      flt_addr  <= w_nf_addr;
    end else if (flt_clr) begin
      flt_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mmu_xbar.sv
// Bench for mmu_xbar: directed scenarios then random batches, checked against
// an address-map / round-robin model. Fault-log checks run with MMU_XBAR_FAULT_LOG_EN.
module tb_mmu_xbar;

  // Requester 1 may not write bank 0 (bit 1*8 + 0*2 + 1 cleared)
  localparam logic [31:0] PERM_P = 32'hFFFF_FDFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, req_we = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  ack, fault;
  logic [63:0] rdata;
`ifdef MMU_XBAR_FAULT_LOG_EN
  logic        flt_valid;
  logic [2:0]  flt_req;
  logic [15:0] flt_addr;
  logic        flt_clr = 1'b0;
`endif

  mmu_xbar #(.PERM(PERM_P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .fault     (fault),
    .rdata     (rdata)
`ifdef MMU_XBAR_FAULT_LOG_EN
    ,
    .flt_valid (flt_valid),
    .flt_req   (flt_req),
    .flt_addr  (flt_addr),
    .flt_clr   (flt_clr)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: address map, permission table, memory image, RR pointers
  int               bases [4] = '{0, 3072, 6144, 7168};
  int               depths[4] = '{3072, 3072, 1024, 3072};
  logic [15:0]      mem_m [int];
  int               ptr   [4] = '{0, 0, 0, 0};
  int               b_addr[4];
  logic [15:0]      b_wd  [4];
  int               pool  [12] = '{0, 5, 16, 3071, 3072, 6143, 6144, 7167, 7168, 10239, 10240, 65535};

  function automatic int bank_of(input int a);
    for (int b = 0; b < 4; b++)
      if (a >= bases[b] && a < bases[b] + depths[b]) return b;
    return -1;
  endfunction

  function automatic bit allowed(input int r, input int b, input bit we);
    logic [31:0] p;
    p = PERM_P;
    return p[r*8 + b*2 + (we ? 1 : 0)];
  endfunction

  // Issue requests from all masked requesters at one edge; expected ack cycle
  // counts edges after the sampling edge (fault 1, k-th grant in a bank 2+k).
  task automatic batch(input logic [3:0] m, input logic [3:0] wem, input string tag);
    int          ecyc[4], gcyc[4], bk[4];
    logic        eflt[4], gflt[4];
    logic [15:0] erd[4], grd[4];
    bit          known[4];
    int          k, last, r;
    for (int i = 0; i < 4; i++) begin
      ecyc[i] = -1; gcyc[i] = -1; eflt[i] = 0; gflt[i] = 0;
      erd[i] = 0; grd[i] = 0; known[i] = 0;
      bk[i] = bank_of(b_addr[i]);
      if (m[i] && (bk[i] < 0 || !allowed(i, bk[i], wem[i]))) begin
        ecyc[i] = 1; eflt[i] = 1; erd[i] = 0; known[i] = 1;
      end
    end
    for (int b = 0; b < 4; b++) begin
      k = 0; last = 0;
      for (int j = 0; j < 4; j++) begin
        r = (ptr[b] + j) % 4;
        if (m[r] && !eflt[r] && bk[r] == b) begin
          ecyc[r] = 2 + k; k++; last = r;
          if (wem[r]) begin
            erd[r] = 0; known[r] = 1; mem_m[b_addr[r]] = b_wd[r];
          end else if (mem_m.exists(b_addr[r])) begin
            erd[r] = mem_m[b_addr[r]]; known[r] = 1;
          end
        end
      end
      if (k > 0) ptr[b] = (last + 1) % 4;
    end

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_we[i] = wem[i];
      req_addr[i*16 +: 16] = 16'(b_addr[i]);
      req_wdata[i*16 +: 16] = b_wd[i];
      req[i] = m[i];
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) begin
          gcyc[i] = c; gflt[i] = fault[i]; grd[i] = rdata[i*16 +: 16];
          req[i] = 1'b0;
        end
      end
      if (req == 4'b0) break;
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        check($sformatf("%s r%0d ack_cycle", tag, i), gcyc[i], ecyc[i]);
        check($sformatf("%s r%0d fault", tag, i), 32'(gflt[i]), 32'(eflt[i]));
        if (known[i]) check($sformatf("%s r%0d rdata", tag, i), 32'(grd[i]), 32'(erd[i]));
      end
    end
    @(posedge clk); #1;
    check($sformatf("%s idle_ack", tag), 32'(ack), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset ack", 32'(ack), 32'h0);
    check("reset fault", 32'(fault), 32'h0);
    check("reset rdata", rdata[31:0], 32'h0);
    rst_n = 1'b1;

    // Single read after preload
    b_addr[0] = 5; b_wd[0] = 16'hBEEF;
    batch(4'b0001, 4'b0001, "t1_wr");
    batch(4'b0001, 4'b0000, "t1_rd");

    // Write/read on bank3, then parallel reads on two banks
    b_addr[3] = 16'h1C00; b_wd[3] = 16'h1234;
    batch(4'b1000, 4'b1000, "t2_wr");
    batch(4'b1000, 4'b0000, "t2_rd");
    b_addr[0] = 0; b_wd[0] = 16'h1111;
    batch(4'b0001, 4'b0001, "t2_pre");
    batch(4'b1001, 4'b0000, "t2_par");

    // Full contention on bank1, twice
    for (int i = 0; i < 4; i++) begin b_addr[i] = 3072 + i*17; b_wd[i] = 16'hA000 + 16'(i); end
    batch(4'b1111, 4'b1111, "t3_wr");
    batch(4'b1111, 4'b0000, "t3_rd");

    // Permission fault leaves RAM unchanged; unmapped read faults
    b_addr[0] = 16'h10; b_wd[0] = 16'h5A5A;
    batch(4'b0001, 4'b0001, "t4_pre");
    b_addr[1] = 16'h10; b_wd[1] = 16'hDEAD;
    batch(4'b0010, 4'b0010, "t4_wflt");
    batch(4'b0001, 4'b0000, "t4_chk");
    b_addr[2] = 16'hF000;
    batch(4'b0100, 4'b0000, "t4_unmap");
    b_addr[2] = 10240;
    batch(4'b0100, 4'b0000, "t4_edge");

    // Reset while r0 waits in arbitration
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[15:0] = 16'd5; req[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("t5 ack_in_reset", 32'(ack), 32'h0);
    check("t5 rdata_in_reset", rdata[31:0], 32'h0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ptr[i] = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("t5 ack_after_release c%0d", c), 32'(ack), 32'h0);
    end
    b_addr[0] = 5;
    batch(4'b0001, 4'b0000, "t5_reissue");

`ifdef MMU_XBAR_FAULT_LOG_EN
    @(negedge clk); flt_clr = 1'b1;
    @(negedge clk); flt_clr = 1'b0;
    check("t6 cleared", 32'(flt_valid), 32'h0);
    b_addr[1] = 16'h10; b_wd[1] = 16'h0BAD;
    batch(4'b0010, 4'b0010, "t6_f1");
    b_addr[2] = 16'hF000;
    batch(4'b0100, 4'b0000, "t6_f2");
    check("t6 valid", 32'(flt_valid), 32'h1);
    check("t6 req_first", 32'(flt_req), 32'h1);
    check("t6 addr_first", 32'(flt_addr), 32'h10);
    @(negedge clk); flt_clr = 1'b1;
    @(negedge clk); flt_clr = 1'b0;
    check("t6 valid_clr", 32'(flt_valid), 32'h0);
    batch(4'b0100, 4'b0000, "t6_f3");
    check("t6 req_next", 32'(flt_req), 32'h2);
    check("t6 addr_next", 32'(flt_addr), 32'hF000);
`endif

    // Random batches over bank edges and unmapped addresses
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        b_addr[i] = pool[$urandom_range(0, 11)];
        b_wd[i]   = 16'($urandom);
      end
      batch(4'($urandom_range(1, 15)), 4'($urandom), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
